// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache that stalls the pipeline on a miss
// and moves whole lines to/from backing memory over a req/ack handshake.
module dcache_ctrl #(
    parameter int LINES  = 32,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(LINES);
    typedef enum logic [1:0] {IDLE, WB, FETCH, REFILL} state_t;
    state_t state, state_nx;
    logic [LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags [LINES];
    logic [LINE_W-1:0] lines [LINES];
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag_a;
    logic [7:0] sel;
    logic [LINE_W-1:0] line;
    logic req, hit, ack, wr_hit, fill, unused_ok;

    assign idx = cpu_addr_i[5 +: IDX_W];
    assign tag_a = cpu_addr_i[31 -: TAG_W];
    assign sel = {cpu_addr_i[4:2], 5'b0};
    assign line = lines[idx];
    assign req = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit = valid[idx] && tags[idx] == tag_a;
    // enable is only ever high in WB/FETCH, so this also drops stray or post-reset acks
    assign ack = mem_ack_i & mem_enable_o;
    assign wr_hit = state == IDLE && hit && cpu_MemWrite_i;
    assign fill = state == FETCH && ack;
    assign unused_ok = ^cpu_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            mem_enable_o <= 1'b0;
        end else begin
            state <= state_nx;
            mem_enable_o <= (state == WB || state == FETCH) && !ack;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req && !hit) state_nx = (dirty[idx] && valid[idx]) ? WB : FETCH;
            WB:      if (ack) state_nx = FETCH;
            FETCH:   if (ack) state_nx = REFILL;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall_o = req && !(state == IDLE && hit);
        cpu_data_o = (state == IDLE && hit && cpu_MemRead_i && !cpu_MemWrite_i) ? line[sel +: 32] : 32'b0;
        mem_write_o = state == WB;
        mem_addr_o = state == WB ? {tags[idx], idx, 5'b0} :
                     state == FETCH ? {cpu_addr_i[31:5], 5'b0} : 32'b0;
        mem_data_o = state == WB ? line : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            lines[idx] <= mem_data_i;
            tags[idx] <= tag_a;
        end else if (wr_hit) begin
            lines[idx][sel +: 32] <= cpu_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scenario tasks plus randomized traffic, checked against a word-level memory model
// and a per-line valid/dirty/tag model of the cache.
module tb_dcache_ctrl;
    logic clk = 1'b0, rst_i, rd, wr, stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0] addr, wdata, cpu_data_o, mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    typedef struct {bit w; logic [31:0] a; logic [255:0] d;} tr_t;
    tr_t tq[$], eq[$];
    logic [255:0] bmem [bit [26:0]];
    logic [255:0] imem [bit [26:0]];
    logic [31:0] arch [bit [29:0]];
    bit m_valid [32], m_dirty [32];
    logic [21:0] m_tag [32];
    int lat = 2, checks = 0, errors = 0, exp_cyc;
    bit auto_mem = 1'b1;
    logic manual_ack = 1'b0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr),
        .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_data_o(cpu_data_o), .stall_o(stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    function automatic logic [255:0] mem_line(bit [26:0] ln);
        logic [255:0] v;
        if (!bmem.exists(ln)) begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            bmem[ln] = v;
            imem[ln] = v;
        end
        return bmem[ln];
    endfunction

    // architectural value of a word: last store, else the backing memory's content
    function automatic logic [31:0] exp_word(logic [31:0] a);
        logic [255:0] l;
        void'(mem_line(a[31:5]));
        l = imem[a[31:5]];
        return arch.exists(a[31:2]) ? arch[a[31:2]] : l[a[4:2]*32 +: 32];
    endfunction

    // stall cycles: fetch = 1 idle + 1 pre-enable + (lat+1) enabled + 1 refill; write-back adds lat+2
    function automatic void model_access(bit w, logic [31:0] a, logic [31:0] d);
        int i = int'(a[9:5]);
        logic [21:0] t = a[31:10];
        logic [255:0] v;
        tr_t x;
        eq.delete();
        exp_rdata = exp_word(a);
        if (m_valid[i] && m_tag[i] == t) exp_cyc = 0;
        else begin
            exp_cyc = lat + 4;
            if (m_dirty[i]) begin
                for (int k = 0; k < 8; k++) v[k*32 +: 32] = exp_word({m_tag[i], i[4:0], k[2:0], 2'b00});
                x.w = 1'b1; x.a = {m_tag[i], i[4:0], 5'b0}; x.d = v;
                eq.push_back(x);
                exp_cyc += lat + 2;
            end
            x.w = 1'b0; x.a = {a[31:5], 5'b0}; x.d = '0;
            eq.push_back(x);
            m_valid[i] = 1'b1; m_tag[i] = t; m_dirty[i] = 1'b0;
        end
        if (w) begin
            arch[a[31:2]] = d;
            m_dirty[i] = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) begin
            m_valid[k] = 1'b0;
            m_dirty[k] = 1'b0;
        end
        arch.delete();
        imem = bmem;
    endfunction

    function automatic bit tq_ok();
        if (tq.size() != eq.size()) return 1'b0;
        foreach (tq[k]) if (tq[k].w !== eq[k].w || tq[k].a !== eq[k].a || tq[k].d !== eq[k].d) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                              output int cyc, output logic fst, output logic [31:0] rdat);
        tq.delete();
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        fst = stall_o;
        cyc = 0;
        while (stall_o && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        rdat = cpu_data_o;
    endtask

    initial begin
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            mem_ack_i = manual_ack;
            if (auto_mem && mem_enable_o) begin
                tr_t x;
                x.w = mem_write_o; x.a = mem_addr_o; x.d = mem_write_o ? mem_data_o : '0;
                repeat (lat) begin
                    @(negedge clk);
                    checks++;
                    if (mem_enable_o !== 1'b1 || mem_write_o !== x.w || mem_addr_o !== x.a || (x.w && mem_data_o !== x.d)) begin
                        errors++;
                        $display("FAIL mem_hold got en=%b wr=%b addr=%h exp en=1 wr=%b addr=%h", mem_enable_o, mem_write_o, mem_addr_o, x.w, x.a);
                    end
                end
                if (x.w) bmem[x.a[31:5]] = x.d;
                else mem_data_i = mem_line(x.a[31:5]);
                tq.push_back(x);
                mem_ack_i = 1'b1;
            end
        end
    end

    task automatic test_reset();
        rst_i = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", mem_enable_o); end
        checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", mem_write_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
        checks++; if (mem_data_o !== 256'h0) begin errors++; $display("FAIL reset_mdata got=%h exp=0", mem_data_o); end
        checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cdata got=%h exp=0", cpu_data_o); end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_miss_fetch();
        logic [255:0] l;
        int cyc;
        logic fs;
        logic [31:0] rv;
        l = mem_line(27'd2);
        l[31:0] = 32'hDEAD_BEEF;
        l[95:64] = 32'hDEAD_BEEF;
        bmem[27'd2] = l;
        imem[27'd2] = l;
        lat = 10;
        model_access(1'b0, 32'h40, 32'h0);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, fs, rv);
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL t1_first_stall got=%b exp=1", fs); end
        checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL t1_stall_cycles got=%0d exp=%0d", cyc, exp_cyc); end
        checks++; if (rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata got=%h exp=deadbeef", rv); end
        checks++; if (!tq_ok()) begin errors++; $display("FAIL t1_trans got=%0d txns first_addr=%h exp=1 fetch at 00000040", tq.size(), tq.size() ? tq[0].a : 32'h0); end
    endtask

    task automatic test_hit();
        int cyc;
        logic fs;
        logic [31:0] rv;
        model_access(1'b0, 32'h48, 32'h0);
        run_access(1'b1, 1'b0, 32'h48, 32'h0, cyc, fs, rv);
        checks++; if (fs !== 1'b0 || cyc != 0) begin errors++; $display("FAIL t2_stall got=%b/%0d exp=0/0", fs, cyc); end
        checks++; if (rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t2_rdata got=%h exp=deadbeef", rv); end
        checks++; if (tq.size() != 0) begin errors++; $display("FAIL t2_trans got=%0d exp=0", tq.size()); end
    endtask

    task automatic test_store_hit();
        int cyc;
        logic fs;
        logic [31:0] rv;
        model_access(1'b1, 32'h44, 32'h1234_5678);
        run_access(1'b0, 1'b1, 32'h44, 32'h1234_5678, cyc, fs, rv);
        checks++; if (cyc != 0) begin errors++; $display("FAIL t3_store_stall got=%0d exp=0", cyc); end
        checks++; if (tq.size() != 0) begin errors++; $display("FAIL t3_store_trans got=%0d exp=0", tq.size()); end
        model_access(1'b0, 32'h44, 32'h0);
        run_access(1'b1, 1'b0, 32'h44, 32'h0, cyc, fs, rv);
        checks++; if (cyc != 0) begin errors++; $display("FAIL t3_load_stall got=%0d exp=0", cyc); end
        checks++; if (rv !== 32'h1234_5678) begin errors++; $display("FAIL t3_rdata got=%h exp=12345678", rv); end
    endtask

    task automatic test_evict();
        int cyc;
        logic fs;
        logic [31:0] rv;
        lat = 3;
        model_access(1'b0, 32'h440, 32'h0);
        run_access(1'b1, 1'b0, 32'h440, 32'h0, cyc, fs, rv);
        checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL t4_stall_cycles got=%0d exp=%0d", cyc, exp_cyc); end
        checks++;
        if (!(tq.size() == 2 && tq[0].w && tq[0].a == 32'h40 && tq[0].d[63:32] == 32'h1234_5678 && !tq[1].w && tq[1].a == 32'h440)) begin
            errors++; $display("FAIL t4_order got=%0d txns exp=wb@40 then fetch@440", tq.size());
        end
        checks++; if (!tq_ok()) begin errors++; $display("FAIL t4_wb_line got=%0d txns exp=%0d matching model", tq.size(), eq.size()); end
        checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL t4_rdata got=%h exp=%h", rv, exp_rdata); end
    endtask

    task automatic test_store_miss();
        int cyc;
        logic fs;
        logic [31:0] rv, d;
        d = $urandom;
        lat = 2;
        model_access(1'b1, 32'h80, d);
        run_access(1'b0, 1'b1, 32'h80, d, cyc, fs, rv);
        checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL t5_stall_cycles got=%0d exp=%0d", cyc, exp_cyc); end
        checks++; if (!(tq.size() == 1 && !tq[0].w && tq[0].a == 32'h80)) begin errors++; $display("FAIL t5_fetch_only got=%0d txns exp=1 fetch@80", tq.size()); end
        model_access(1'b0, 32'h80, 32'h0);
        run_access(1'b1, 1'b0, 32'h80, 32'h0, cyc, fs, rv);
        checks++; if (cyc != 0 || rv !== d) begin errors++; $display("FAIL t5_readback got=%h/%0d exp=%h/0", rv, cyc, d); end
        model_access(1'b0, 32'h480, 32'h0);
        run_access(1'b1, 1'b0, 32'h480, 32'h0, cyc, fs, rv);
        checks++; if (!(tq.size() == 2 && tq[0].w && tq[0].a == 32'h80 && tq[0].d[31:0] == d)) begin errors++; $display("FAIL t5_evict got=%0d txns exp=wb@80 word0=%h", tq.size(), d); end
        checks++; if (!tq_ok() || cyc != exp_cyc) begin errors++; $display("FAIL t5_evict_model got=%0d cyc exp=%0d", cyc, exp_cyc); end
    endtask

    task automatic test_random();
        int cyc, sel;
        logic fs;
        logic [31:0] rv, a, d;
        bit r, w;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 4);
            a = {20'h0, 2'($urandom_range(0, 3)), (sel == 4) ? 5'd31 : 5'(sel), 3'($urandom_range(0, 7)), 2'b00};
            d = $urandom;
            sel = $urandom_range(0, 3);
            r = sel != 2;
            w = sel >= 2;
            lat = $urandom_range(1, 4);
            model_access(w, a, d);
            run_access(r, w, a, d, cyc, fs, rv);
            checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL rnd_stall n=%0d addr=%h got=%0d exp=%0d", n, a, cyc, exp_cyc); end
            checks++; if (!tq_ok()) begin errors++; $display("FAIL rnd_trans n=%0d addr=%h got=%0d txns exp=%0d", n, a, tq.size(), eq.size()); end
            if (r && !w) begin
                checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, a, rv, exp_rdata); end
            end
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        logic fs;
        logic [31:0] rv;
        @(negedge clk);
        rst_i = 1'b1; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        auto_mem = 1'b0;
        @(negedge clk);
        rd = 1'b1; addr = 32'h40;
        n = 0;
        while (mem_enable_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h40) begin errors++; $display("FAIL t6_fetch_start got en=%b wr=%b addr=%h exp=1/0/00000040", mem_enable_o, mem_write_o, mem_addr_o); end
        @(negedge clk);
        rst_i = 1'b1; rd = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++; if (mem_enable_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL t6_after_reset got en=%b stall=%b exp=0/0", mem_enable_o, stall_o); end
        #1 manual_ack = 1'b1;
        @(negedge clk);
        #2 manual_ack = 1'b0;
        checks++; if (mem_ack_i !== 1'b1 || mem_enable_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL t6_late_ack got ack=%b en=%b stall=%b exp=1/0/0", mem_ack_i, mem_enable_o, stall_o); end
        @(negedge clk);
        #1;
        checks++; if (mem_enable_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL t6_ack_ignored got en=%b stall=%b exp=0/0", mem_enable_o, stall_o); end
        auto_mem = 1'b1;
        lat = 3;
        model_access(1'b0, 32'h40, 32'h0);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, fs, rv);
        checks++; if (fs !== 1'b1 || cyc != exp_cyc) begin errors++; $display("FAIL t6_remiss got=%b/%0d exp=1/%0d", fs, cyc, exp_cyc); end
        checks++; if (!tq_ok()) begin errors++; $display("FAIL t6_trans got=%0d txns exp=1 fetch@40", tq.size()); end
        checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL t6_rdata got=%h exp=%h", rv, exp_rdata); end
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_miss_fetch();
        test_hit();
        test_store_hit();
        test_evict();
        test_store_miss();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
